// File: rtl/pi_lock_sequencer.sv
// Lock-acquisition sequencer for the PIG_v3 phase servo: IDLE -> ACQUIRE -> LOCKED, with FAULT/relock.
// Optional KI ramp on lock entry is built only when PI_SEQ_RAMP_EN is defined.
module pi_lock_sequencer #(
  parameter int INPUT_WIDTH   = 14,
  parameter int SETTLE_CYCLES = 1024,
  parameter int UNLOCK_CYCLES = 16,
  parameter int ACQ_TIMEOUT   = 1 << 20,
  parameter int RST_HOLD      = 8,
  parameter int RAMP_CYCLES   = 256,
  parameter int CNT_WIDTH     = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [INPUT_WIDTH-1:0] PV,
  input  logic        [INPUT_WIDTH-1:0] lock_thresh,
  input  logic        [INPUT_WIDTH-1:0] unlock_thresh,
  input  logic signed [7:0]             kp_acq,
  input  logic signed [7:0]             ki_acq,
  input  logic signed [7:0]             kg_acq,
  input  logic signed [7:0]             kp_lock,
  input  logic signed [7:0]             ki_lock,
  input  logic signed [7:0]             kg_lock,
  input  logic                          kg_sign_cfg,
  output logic signed [7:0]             KP,
  output logic signed [7:0]             KI,
  output logic signed [7:0]             KG,
  output logic                          KGSign,
  output logic                          pi_rst,
  output logic                          locked,
  output logic [1:0]                    state,
  output logic [15:0]                   relock_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // Terminal values: a transition fires on the edge where the counter already holds N-1.
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST  = CNT_WIDTH'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(ACQ_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD - 1);

  logic [1:0]             state_n;
  logic [CNT_WIDTH-1:0]   settle_cnt, settle_n;
  logic [CNT_WIDTH-1:0]   timeout_cnt, timeout_n;
  logic [CNT_WIDTH-1:0]   unlock_cnt, unlock_n;
  logic [CNT_WIDTH-1:0]   hold_cnt, hold_n;
  logic signed [7:0]      kp_n, ki_n, kg_n;
  logic [15:0]            relock_n;
  logic [INPUT_WIDTH-1:0] pv_mag;
  logic                   in_lock;
  logic                   over_unlock;

  // Unsigned magnitude: the most negative PV maps to 2^(INPUT_WIDTH-1) instead of wrapping.
  assign pv_mag      = PV[INPUT_WIDTH-1] ? $unsigned(-PV) : $unsigned(PV);
  assign in_lock     = (pv_mag <= lock_thresh);
  assign over_unlock = (pv_mag > unlock_thresh);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    settle_n  = '0;
    timeout_n = '0;
    unlock_n  = '0;
    hold_n    = '0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (in_lock && (settle_cnt == SETTLE_LAST)) begin
            state_n = ST_LOCKED;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state_n = ST_FAULT;
          end else begin
            settle_n  = in_lock ? settle_cnt + 1'b1 : '0;
            timeout_n = timeout_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (over_unlock && (unlock_cnt == UNLOCK_LAST)) begin
            state_n = ST_FAULT;
          end else begin
            unlock_n = over_unlock ? unlock_cnt + 1'b1 : '0;
          end
        end
        ST_FAULT: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = ST_ACQUIRE;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef PI_SEQ_RAMP_EN
  localparam logic [CNT_WIDTH-1:0] RAMP_LAST = CNT_WIDTH'(RAMP_CYCLES - 1);

  logic [CNT_WIDTH-1:0] ramp_cnt, ramp_n;
  logic signed [7:0]    ki_ramp;

  // KI itself is the ramp accumulator; entering LOCKED reloads it from ki_acq.
  always_comb begin
    ramp_n  = '0;
    ki_ramp = ki_acq;
    if ((state == ST_LOCKED) && (state_n == ST_LOCKED)) begin
      if (ramp_cnt == RAMP_LAST) begin
        if (KI < ki_lock) begin
          ki_ramp = KI + 8'sd1;
        end else if (KI > ki_lock) begin
          ki_ramp = KI - 8'sd1;
        end else begin
          ki_ramp = KI;
        end
      end else begin
        ramp_n  = ramp_cnt + 1'b1;
        ki_ramp = KI;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_n;
    end
  end
`endif

  always_comb begin
    kp_n = '0;
    ki_n = '0;
    kg_n = '0;
    case (state_n)
      ST_ACQUIRE: begin
        kp_n = kp_acq;
        ki_n = ki_acq;
        kg_n = kg_acq;
      end
      ST_LOCKED: begin
        kp_n = kp_lock;
`ifdef PI_SEQ_RAMP_EN
        ki_n = ki_ramp;
`else
        ki_n = ki_lock;
`endif
        kg_n = kg_lock;
      end
      default: ;
    endcase
  end

  always_comb begin
    relock_n = relock_count;
    if ((state_n == ST_FAULT) && (state != ST_FAULT) && (relock_count != 16'hFFFF)) begin
      relock_n = relock_count + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
      unlock_cnt   <= '0;
      hold_cnt     <= '0;
      KP           <= '0;
      KI           <= '0;
      KG           <= '0;
      KGSign       <= 1'b0;
      pi_rst       <= 1'b1;
      locked       <= 1'b0;
      relock_count <= '0;
    end else begin
      state        <= state_n;
      settle_cnt   <= settle_n;
      timeout_cnt  <= timeout_n;
      unlock_cnt   <= unlock_n;
      hold_cnt     <= hold_n;
      KP           <= kp_n;
      KI           <= ki_n;
      KG           <= kg_n;
      KGSign       <= kg_sign_cfg;
      pi_rst       <= (state_n == ST_IDLE) || (state_n == ST_FAULT);
      locked       <= (state_n == ST_LOCKED);
      relock_count <= relock_n;
    end
  end

endmodule

// File: tb/tb_pi_lock_sequencer.sv
// Scoreboard bench for pi_lock_sequencer: stimulus queues the expected post-edge outputs,
// a monitor pops and compares them after every rising edge.
module tb_pi_lock_sequencer;

  localparam logic signed [7:0] KPA  = 8'sd2;
  localparam logic signed [7:0] KPA2 = 8'sd7;
  localparam logic signed [7:0] KIA  = -8'sd4;
  localparam logic signed [7:0] KGA  = 8'sd3;
  localparam logic signed [7:0] KPL  = 8'sd5;
  localparam logic signed [7:0] KIL  = -8'sd1;
  localparam logic signed [7:0] KGL  = 8'sd6;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [13:0] pv;
  logic [13:0]        lock_thresh, unlock_thresh;
  logic signed [7:0]  kp_acq, ki_acq, kg_acq, kp_lock, ki_lock, kg_lock;
  logic               kg_sign_cfg;
  logic signed [7:0]  KP, KI, KG;
  logic               KGSign, pi_rst, locked;
  logic [1:0]         state;
  logic [15:0]        relock_count;

  pi_lock_sequencer #(
    .INPUT_WIDTH(14), .SETTLE_CYCLES(4), .UNLOCK_CYCLES(3), .ACQ_TIMEOUT(20),
    .RST_HOLD(2), .RAMP_CYCLES(2), .CNT_WIDTH(24)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .PV(pv),
    .lock_thresh(lock_thresh), .unlock_thresh(unlock_thresh),
    .kp_acq(kp_acq), .ki_acq(ki_acq), .kg_acq(kg_acq),
    .kp_lock(kp_lock), .ki_lock(ki_lock), .kg_lock(kg_lock),
    .kg_sign_cfg(kg_sign_cfg),
    .KP(KP), .KI(KI), .KG(KG), .KGSign(KGSign), .pi_rst(pi_rst),
    .locked(locked), .state(state), .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        st;
    logic [15:0]       rc;
    logic signed [7:0] kp, ki, kg;
    bit                gchk;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [44:0] pack(logic [1:0] st, logic pr, logic lk, logic gs,
                                       logic [15:0] rc, logic [7:0] kp, logic [7:0] ki,
                                       logic [7:0] kg);
    return {st, pr, lk, gs, rc, kp, ki, kg};
  endfunction

  task automatic check(input string name, input logic [44:0] act, input logic [44:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (state,pi_rst,locked,KGSign,relock,KP,KI,KG)",
               name, act, want);
    end
  endtask

  // Expected KI for the n-th LOCKED cycle (0 = entry): -4,-4,-3,-3,-2,-2,-1,... with the ramp.
  function automatic logic signed [7:0] ki_lk(int n);
    int v;
`ifdef PI_SEQ_RAMP_EN
    v = -4 + n / 2;
    if (v > -1) v = -1;
`else
    v = -1;
`endif
    return v[7:0];
  endfunction

  // Called at a falling edge: drive, queue expectation for the next rising edge, wait.
  task automatic cyc(input logic signed [13:0] p, input logic en, input logic [1:0] st,
                     input logic [15:0] rc, input logic signed [7:0] kp,
                     input logic signed [7:0] ki, input logic signed [7:0] kg,
                     input bit gchk, input string name);
    exp_t e;
    pv     = p;
    enable = en;
    e.st = st; e.rc = rc; e.kp = kp; e.ki = ki; e.kg = kg; e.gchk = gchk; e.name = name;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name,
              pack(state, pi_rst, locked, KGSign, relock_count,
                   e.gchk ? KP : 8'h00, e.gchk ? KI : 8'h00, e.gchk ? KG : 8'h00),
              pack(e.st, (e.st == 2'd0) || (e.st == 2'd3), e.st == 2'd2, 1'b1, e.rc,
                   e.kp, e.ki, e.kg));
      end
    end
  end

  initial begin : stim
    logic signed [13:0] settle_pv [6];
    logic signed [13:0] edge_pv [7];
    int guard;
    settle_pv = '{14'sd5, 14'sd5, -14'sd11, 14'sd5, 14'sd5, 14'sd5};
    edge_pv   = '{14'sd8191, -14'sd8191, 14'sd0, 14'h2000, 14'sd0, 14'sd0, 14'sd0};

    rst = 1'b1; enable = 1'b0; pv = '0;
    lock_thresh = 14'd10; unlock_thresh = 14'd50;
    kp_acq = KPA; ki_acq = KIA; kg_acq = KGA;
    kp_lock = KPL; ki_lock = KIL; kg_lock = KGL;
    kg_sign_cfg = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_values", pack(state, pi_rst, locked, KGSign, relock_count, KP, KI, KG),
          pack(2'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 8'h00));
    rst = 1'b0;
    repeat (3) cyc(14'sd0, 1'b0, 2'd0, 16'd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, "idle_hold");

    // Acquire; the -11 sample restarts the settle count, lock on 4th trailing in-threshold sample.
    cyc(14'sd0, 1'b1, 2'd1, 16'd0, KPA, KIA, KGA, 1'b1, "acq_entry");
    foreach (settle_pv[i]) cyc(settle_pv[i], 1'b1, 2'd1, 16'd0, KPA, KIA, KGA, 1'b1, "acq_settle");
    cyc(14'sd5, 1'b1, 2'd2, 16'd0, KPL, ki_lk(0), KGL, 1'b1, "lock_entry");
    for (int n = 1; n <= 7; n++) cyc(14'sd0, 1'b1, 2'd2, 16'd0, KPL, ki_lk(n), KGL, 1'b1, "lock_ki");

    // Two over-threshold samples, a good one, then three in a row to unlock.
    cyc(-14'sd200, 1'b1, 2'd2, 16'd0, KPL, ki_lk(8), KGL, 1'b1, "unlock_1of2");
    cyc(-14'sd200, 1'b1, 2'd2, 16'd0, KPL, ki_lk(9), KGL, 1'b1, "unlock_2of2");
    cyc(14'sd0, 1'b1, 2'd2, 16'd0, KPL, ki_lk(10), KGL, 1'b1, "unlock_clear");
    cyc(-14'sd200, 1'b1, 2'd2, 16'd0, KPL, ki_lk(11), KGL, 1'b1, "unlock_1of3");
    cyc(-14'sd200, 1'b1, 2'd2, 16'd0, KPL, ki_lk(12), KGL, 1'b1, "unlock_2of3");
    cyc(-14'sd200, 1'b1, 2'd3, 16'd1, 8'sd0, 8'sd0, 8'sd0, 1'b0, "unlock_fault");
    cyc(14'sd0, 1'b1, 2'd3, 16'd1, 8'sd0, 8'sd0, 8'sd0, 1'b0, "fault_hold");
    cyc(14'sd100, 1'b1, 2'd1, 16'd1, KPA, KIA, KGA, 1'b1, "fault_to_acq");

    // Never settles: 20 ACQUIRE cycles then FAULT; kp_acq changes live mid-way.
    for (int i = 1; i <= 19; i++) begin
      if (i == 10) kp_acq = KPA2;
      cyc(14'sd100, 1'b1, 2'd1, 16'd1, (i >= 10) ? KPA2 : KPA, KIA, KGA, 1'b1, "acq_timeout_run");
    end
    kp_acq = KPA;
    cyc(14'sd100, 1'b1, 2'd3, 16'd2, 8'sd0, 8'sd0, 8'sd0, 1'b0, "timeout_fault");
    cyc(14'sd0, 1'b1, 2'd3, 16'd2, 8'sd0, 8'sd0, 8'sd0, 1'b0, "fault_hold2");
    cyc(14'sd0, 1'b1, 2'd1, 16'd2, KPA, KIA, KGA, 1'b1, "acq_reentry");

    // Threshold boundary: +/-8191 are in, -8192 reads as 8192 and restarts the count.
    lock_thresh = 14'd8191;
    foreach (edge_pv[i]) cyc(edge_pv[i], 1'b1, 2'd1, 16'd2, KPA, KIA, KGA, 1'b1, "acq_boundary");
    cyc(14'sd0, 1'b1, 2'd2, 16'd2, KPL, ki_lk(0), KGL, 1'b1, "lock_boundary");
    cyc(14'sd0, 1'b0, 2'd0, 16'd2, 8'sd0, 8'sd0, 8'sd0, 1'b1, "disable_idle");

    // Asynchronous reset in the middle of ACQUIRE.
    cyc(14'sd0, 1'b1, 2'd1, 16'd2, KPA, KIA, KGA, 1'b1, "reacquire");
    #1 rst = 1'b1;
    #1 check("async_rst", pack(state, pi_rst, locked, KGSign, relock_count, KP, KI, KG),
             pack(2'd0, 1'b1, 1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    rst = 1'b0;
    cyc(14'sd0, 1'b0, 2'd0, 16'd0, 8'sd0, 8'sd0, 8'sd0, 1'b1, "post_rst_idle");

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
